// File: rtl/not16_pkg.sv
// Shared gate-library definitions for the 16-bit word primitives.
package not16_pkg;
  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t WORD_ZERO = 16'h0000;
  localparam word_t WORD_ONES = 16'hFFFF;
endpackage : not16_pkg

// File: rtl/nand2.sv
// Two-input NAND, the base primitive of the gate library.
module nand2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule : nand2

// File: rtl/not16_not1.sv
// 1-bit inverter built from a single NAND with both inputs tied together.
module not1 (
  input  logic a,
  output logic y
);
  nand2 u_nand2 (
    .a (a),
    .b (a),
    .y (y)
  );
endmodule : not1

// File: rtl/not16.sv
// Word-wide bitwise inverter with a combinational output and an optional
// enable-captured registered copy.
module not16
  import not16_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] word_d, word_q;
  logic             valid_d, valid_q;

  // Each output bit sees only its own input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    not1 u_not1 (
      .a (in[i]),
      .y (out[i])
    );
  end

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (en) begin
      word_d  = out;
      valid_d = 1'b1;
    end
  end

  // Valid is sticky until the next reset, not a per-capture strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign out_q     = word_q;
  assign out_valid = valid_q;

endmodule : not16

// File: tb/tb_not16.sv
// Directed-vector bench for not16: combinational mapping and capture register.
module tb_not16;
  import not16_pkg::*;

  logic  clk = 1'b0;
  logic  clk_run = 1'b0;
  logic  rst_n = 1'b0;
  logic  en = 1'b0;
  word_t in_w = WORD_ZERO;
  word_t out_w, out_q_w;
  logic  out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  not16 #(.WIDTH(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_w),
    .en        (en),
    .out       (out_w),
    .out_q     (out_q_w),
    .out_valid (out_valid)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  logic [15:0] dir_in  [5] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
  logic [15:0] dir_exp [5] = '{16'hFFFF, 16'h0000, 16'h5555, 16'hC33C, 16'hEDCB};

  initial begin
    // Reset held low, clock idle: combinational path must still work.
    #1;
    chk("rst_out_q", out_q_w, 16'h0000);
    chk("rst_valid", {15'd0, out_valid}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      in_w = dir_in[i];
      #1;
      chk("dir_out", out_w, dir_exp[i]);
      chk("dir_out_q_hold0", out_q_w, 16'h0000);
    end

    for (int k = 0; k < 16; k++) begin
      logic [15:0] one_hot;
      one_hot = 16'h0001 << k;
      in_w = one_hot;
      #1;
      chk("walk1", out_w, one_hot ^ 16'hFFFF);
    end

    begin
      int bad;
      bad = 0;
      for (int v = 0; v < 65536; v++) begin
        logic [15:0] w;
        w = v[15:0];
        in_w = w;
        #1;
        n_chk++;
        if (out_w !== (w ^ 16'hFFFF)) begin
          bad++;
          if (bad <= 5) $display("FAIL sweep: in %h got %h, expected %h", w, out_w, w ^ 16'hFFFF);
        end else begin
          n_pass++;
        end
      end
    end
    chk("sweep_out_q_hold0", out_q_w, 16'h0000);

    // Start clocking; release reset between edges.
    clk_run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_w  = 16'h1234;
    en    = 1'b1;
    @(posedge clk);
    #1;
    chk("cap_out_q", out_q_w, 16'hEDCB);
    chk("cap_valid", {15'd0, out_valid}, 16'h0001);
    en   = 1'b0;
    in_w = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("hold_out_q", out_q_w, 16'hEDCB);
      chk("hold_valid", {15'd0, out_valid}, 16'h0001);
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_q", out_q_w, 16'h0000);
    chk("async_valid", {15'd0, out_valid}, 16'h0000);

    // Re-arm with a known capture, then assert reset on an enabled edge.
    @(negedge clk);
    rst_n = 1'b1;
    in_w  = 16'h1234;
    en    = 1'b1;
    @(posedge clk);
    #1;
    chk("rearm_out_q", out_q_w, 16'hEDCB);
    in_w = 16'hFFFF;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("coinc_out_q", out_q_w, 16'h0000);
    chk("coinc_valid", {15'd0, out_valid}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_out_q", out_q_w, 16'h0000);
    chk("post_valid", {15'd0, out_valid}, 16'h0001);
    chk("post_out", out_w, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_not16
